axis_stream_decoder: RTL
========================

AXIS_STREAM_DECODER -- requirements
Module: axis_stream_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream data width in bits, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 4, output FIFO entries, a power of 2 and at least 2.
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port aresetn, input, 1, the reset, which is asynchronous and active-low.
REQ-005 SHALL have ports mode (input, 2, decode mode: 00 pass, 01 byte-unreverse, 10 subtract, 11 pass) and add_value (input, DATA_WIDTH, the constant the encoder added).
REQ-006 SHALL have slave ports s_axis_tvalid (in, 1), s_axis_tready (out, 1), s_axis_tdata (in, DATA_WIDTH), s_axis_tkeep and s_axis_tstrb (in, DATA_WIDTH/8), and s_axis_tlast (in, 1).
REQ-007 SHALL have master ports m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tdata (out, DATA_WIDTH), m_axis_tkeep and m_axis_tstrb (out, DATA_WIDTH/8), and m_axis_tlast (out, 1).

Function
REQ-008 SHALL accept an input beat on any rising edge where s_axis_tvalid and s_axis_tready are both high.
REQ-009 SHALL drive s_axis_tready = (FIFO occupancy < DEPTH) from registered occupancy; when full, no input bypass occurs even if an output pop happens in the same cycle.
REQ-010 SHALL use two-state packet FSM: IDLE (next accepted beat is first of packet) -> IN_PKT on accepting a non-last beat; IN_PKT -> IDLE on accepting a tlast beat; IDLE stays IDLE on accepting a single-beat tlast packet.
REQ-011 SHALL latch mode and add_value on the first beat of a packet (accept in IDLE) and apply the latched values to all beats of that packet; mode/add_value changes in IN_PKT SHALL be ignored until the next packet.
REQ-012 SHALL, in mode 01, output data with byte i moved to byte (N-1-i), where N = DATA_WIDTH/8, and reverse tkeep/tstrb bit order identically.
REQ-013 SHALL, in mode 10, output data = s_axis_tdata - add_value modulo 2^DATA_WIDTH, with tkeep/tstrb unchanged.
REQ-014 SHALL, in modes 00 and 11, pass data, tkeep, and tstrb unchanged; tlast SHALL always pass unchanged.
REQ-015 SHALL apply the transform before the FIFO write; a beat accepted at edge N SHALL be presented on m_axis with m_axis_tvalid high after edge N (latency 1, no combinational s->m path).
REQ-016 SHALL drive m_axis_tvalid = (occupancy != 0); m_axis_* SHALL be held stable while tvalid is high and tready is low, and SHALL pop on tvalid && tready.
REQ-017 SHALL permit simultaneous push and pop when not full, leaving occupancy unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-018 SHALL preserve beat order and packet boundaries exactly, with no beats dropped or duplicated.

Reset
REQ-019 SHALL, on aresetn low, immediately clear occupancy and pointers, force FSM=IDLE, m_axis_tvalid=0, s_axis_tready=0, m_axis_tdata/tkeep/tstrb/tlast=0, latched mode=00, and latched add_value=0.
REQ-020 SHALL raise s_axis_tready on the first rising edge after aresetn deasserts.
REQ-021 SHALL discard any partially received packet or buffered beats on reset mid-operation; the next accepted beat SHALL be treated as a first beat.

Configuration
REQ-022 SHALL, when macro AXIS_DEC_STATS_EN is defined, add outputs beat_count (32) and pkt_count (16), reset to 0, incremented on each output handshake and each output tlast handshake respectively, wrapping to 0 on overflow.
REQ-023 SHALL, without AXIS_DEC_STATS_EN, omit these ports and counters entirely, with all other behaviour identical.

Verification
REQ-024 Mode 01 first beat, input 0xEFBEADDE tkeep 0011 -> output 0xDEADBEEF tkeep 1100, one cycle later.
REQ-025 Mode 10 with add_value 0x00000001, inputs 0xFACEFEEE then 0x00000000 (tlast) -> outputs 0xFACEFEED then 0xFFFFFFFF tlast=1.
REQ-026 Packet starting in mode 10, mode switched to 01 on beat 2 of 3 -> all 3 beats decoded with subtract; next packet uses 01.
REQ-027 m_axis_tready=0, stream 5 beats -> 4 accepted, s_axis_tready=0 on 5th; tready=1 -> beats drain in order, 5th accepted after first pop.
REQ-028 aresetn pulsed low with 2 beats buffered mid-packet -> m_axis_tvalid=0 immediately, no stale beats output after release, next beat uses freshly latched mode.
REQ-029 With AXIS_DEC_STATS_EN defined, two packets of 2 and 3 beats drained -> beat_count=5, pkt_count=2.

Source files
------------

// File: rtl/axis_stream_decoder.sv
// rtl/axis_stream_decoder.sv - AXI-Stream decoder (pass/byte-unreverse/subtract) with output FIFO; optional stats via AXIS_DEC_STATS_EN
module axis_stream_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [1:0]              mode,
  input  logic [DATA_WIDTH-1:0]   add_value,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast
`ifdef AXIS_DEC_STATS_EN
  ,
  output logic [31:0]             beat_count,
  output logic [15:0]             pkt_count
`endif
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 2 * KW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] add_q;
  logic [CW-1:0]         count_q;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  ready_en;
  logic [EW-1:0]         mem [DEPTH];
  logic [EW-1:0]         head;

  logic                  push, pop;
  logic [1:0]            eff_mode;
  logic [DATA_WIDTH-1:0] eff_add;
  logic [DATA_WIDTH-1:0] t_data;
  logic [KW-1:0]         t_keep, t_strb;

  // Ready comes only from registered state, so a pop never opens a same-cycle bypass
  assign s_axis_tready = ready_en && (count_q != FULL);
  assign m_axis_tvalid = (count_q != '0);
  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  // First beat of a packet uses the live settings; later beats use the latched ones
  assign eff_mode = (state_q == IDLE) ? mode : mode_q;
  assign eff_add  = (state_q == IDLE) ? add_value : add_q;

  // Per-beat transform applied before the FIFO write
  always_comb begin
    t_data = s_axis_tdata;
    t_keep = s_axis_tkeep;
    t_strb = s_axis_tstrb;
    case (eff_mode)
      2'b01: begin
        for (int i = 0; i < KW; i++) begin
          t_data[8*(KW-1-i) +: 8] = s_axis_tdata[8*i +: 8];
          t_keep[KW-1-i]          = s_axis_tkeep[i];
          t_strb[KW-1-i]          = s_axis_tstrb[i];
        end
      end
      2'b10:   t_data = s_axis_tdata - eff_add;
      default: ;
    endcase
  end

  // Packet FSM next state: track whether the next accepted beat opens a packet
  always_comb begin
    state_d = state_q;
    if (push) state_d = s_axis_tlast ? IDLE : IN_PKT;
  end

  // Packet FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Capture decode settings on the first beat of each packet
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q <= 2'b00;
      add_q  <= '0;
    end else if (push && state_q == IDLE) begin
      mode_q <= mode;
      add_q  <= add_value;
    end
  end

  // Hold ready low until the first clock edge after reset release
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= {s_axis_tlast, t_strb, t_keep, t_data};
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Output fields are forced to zero whenever the FIFO is empty (including reset)
  assign head = m_axis_tvalid ? mem[rd_ptr] : '0;
  assign {m_axis_tlast, m_axis_tstrb, m_axis_tkeep, m_axis_tdata} = head;

`ifdef AXIS_DEC_STATS_EN
  // Output beat and packet counters, wrapping on overflow
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_count <= '0;
      pkt_count  <= '0;
    end else if (pop) begin
      beat_count <= beat_count + 1'b1;
      if (m_axis_tlast) pkt_count <= pkt_count + 1'b1;
    end
  end
`endif

endmodule
